nibble_sub_ctrl: RTL and testbench
==================================

# nibble_sub_ctrl

Multi-cycle W-bit two's-complement subtractor that reuses one 4-bit complement-and-add slice, sequenced one nibble per clock from LSB to MSB. It accepts operand pairs on a valid/ready input handshake, runs W/4 RUN cycles, then holds the result on a valid/ready output handshake. It is the width-scaling controller for the team's 4-bit complement datapath in arithmetic units that cannot afford a full-width subtractor.

## Interface
- W, 16, operand width; multiple of 4, ≥4
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operands
- a  in  W  minuend (two's complement / unsigned)
- b  in  W  subtrahend
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  W  a − b mod 2^W
- borrow  out  1  1 when a < b unsigned (= ~final carry)
- ovf  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch a and b, idx=0, carry=1 (the +1 of two's complement), go to RUN.
- RUN, each cycle:
  - s[4:0] = a[idx] + ~b[idx] + carry, nibble-wise.
  - diff[idx] ← s[3:0]; carry ← s[4]; idx++.
  - When idx = W/4−1 is processed, go to DONE.
- DONE:
  - out_valid=1.
  - borrow = ~carry.
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]).
  - On out_ready, go to IDLE.
- Output stability: diff, borrow and ovf are stable throughout DONE and retain their values after return to IDLE until the next RUN begins.
- Input gating:
  - in_ready=0 in RUN and DONE.
  - Operand inputs are ignored except at the accept edge.
- Reset, any state including mid-RUN: go to IDLE; in-flight operation discarded.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, diff=0, borrow=0, ovf=0, idx=0, carry=0.
- idx width: clog2(W/4), minimum 1 bit. It never wraps inside RUN; the exit is decoded at the last index.

## Timing
- Accept edge = rising edge with in_valid & in_ready.
- First RUN cycle is the cycle after the accept edge.
- out_valid rises W/4 cycles after the accept edge (W=16: 4 cycles).
- Earliest next accept is the cycle after the out_valid & out_ready edge.
- Minimum issue interval: W/4 + 2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Same-cycle out_valid & out_ready: the result is consumed and the next cycle is IDLE.

## Configuration
- NIBBLE_SUB_ADD_OP_EN defined:
  - Adds input port `op` (1 bit), latched at accept.
  - op=0: subtract as above.
  - op=1: add; no complement on b, initial carry=0, borrow port reports the final carry-out, ovf = (a[W−1] = b[W−1]) & (diff[W−1] ≠ a[W−1]).
- Undefined: no `op` port; subtract only.

## Structure
- Package nibble_sub_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - NIB_W = 4
  - function computing the nibble count from W
- Sub-module nibble_cmpl_add (combinational):
  - Inputs: 4-bit a, 4-bit b, cin, inv.
  - Output: {cout, sum} = a + (inv ? ~b : b) + cin.
  - Instantiated once and shared across all RUN cycles.

## Test plan
All cases use W=16.
- a=0x1234, b=0x0235 → diff=0x0FFF, borrow=0, ovf=0; out_valid rises 4 cycles after the accept edge.
- a=0x0000, b=0x0001 → diff=0xFFFF, borrow=1, ovf=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, borrow=0, ovf=1. Second op a=0x5A5A, b=0x0000 → diff=0x5A5A, borrow=0, ovf=0.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, diff, borrow and ovf held constant; in_ready=0 throughout; a new in_valid is ignored until IDLE.
- Reset asserted on the 2nd RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, diff=0. A fresh op a=3, b=5 then yields diff=0xFFFE, borrow=1.
- With NIBBLE_SUB_ADD_OP_EN, op=1, a=0x7FFF, b=0x0001 → diff=0x8000, ovf=1, borrow(carry)=0. Then a=0xFFFF, b=0x0001 → diff=0x0000, carry=1, ovf=0.

Source files
------------

// File: rtl/nibble_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package nibble_sub_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of nibble slices needed to cover a w-bit operand.
  function automatic int unsigned nib_count(input int unsigned w);
    return w / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_cmpl_add.sv
// 4-bit complement-and-add slice: {cout, sum} = a + (inv ? ~b : b) + cin.
module nibble_cmpl_add
  import nibble_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic             inv,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] b_eff;

  // Optional one's complement of b, then a single 5-bit add.
  always_comb begin
    b_eff = inv ? ~b : b;
    {cout, sum} = (NIB_W+1)'(a) + (NIB_W+1)'(b_eff) + (NIB_W+1)'(cin);
  end

endmodule

// File: rtl/nibble_sub_ctrl.sv
// Nibble-serial W-bit subtractor controller: one shared 4-bit slice, LSB first.
// Optional add mode (op port) enabled by defining NIBBLE_SUB_ADD_OP_EN.
module nibble_sub_ctrl
  import nibble_sub_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef NIBBLE_SUB_ADD_OP_EN
  input  logic         op,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int unsigned NIB   = nib_count(W);
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             op_q, op_d;
  logic             op_in;

  logic [NIB_W-1:0] a_nib, b_nib, sum_nib;
  logic             cout;

`ifdef NIBBLE_SUB_ADD_OP_EN
  assign op_in = op;
`else
  assign op_in = 1'b0;
`endif

  // Shared slice; complement b only when subtracting.
  nibble_cmpl_add u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .inv  (~op_q),
    .sum  (sum_nib),
    .cout (cout)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      op_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, nibble select/write-back and flag generation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    op_d     = op_q;
    a_nib    = '0;
    b_nib    = '0;

    for (int i = 0; i < int'(NIB); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_in;
          idx_d   = '0;
          carry_d = ~op_in;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NIB); i++) begin
          if (idx_q == IDX_W'(i)) begin
            diff_d[i*NIB_W +: NIB_W] = sum_nib;
          end
        end
        carry_d = cout;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          if (op_q) begin
            borrow_d = cout;
            ovf_d    = (a_q[W-1] == b_q[W-1]) & (sum_nib[NIB_W-1] != a_q[W-1]);
          end else begin
            borrow_d = ~cout;
            ovf_d    = (a_q[W-1] != b_q[W-1]) & (sum_nib[NIB_W-1] != a_q[W-1]);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_sub_ctrl.sv
// Directed self-checking bench for nibble_sub_ctrl (W=16).
// Add-mode vectors run when NIBBLE_SUB_ADD_OP_EN is defined.
module tb_nibble_sub_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nibble_sub_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef NIBBLE_SUB_ADD_OP_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present one operand pair for one edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                       input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_v;
    op       = top;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
  endtask

  // Wait (bounded) for out_valid and check latency and result fields.
  task automatic expect_result(input logic [W-1:0] ed, input logic eb, input logic eo,
                               input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      n++;
      if (n < 4) check_eq({name, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    check_eq({name, "_latency"}, 32'(n), 32'd4);
    check_eq({name, "_diff"}, 32'(diff), 32'(ed));
    check_eq({name, "_borrow"}, 32'(borrow), 32'(eb));
    check_eq({name, "_ovf"}, 32'(ovf), 32'(eo));
    check_eq({name, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  // Consume the result in one cycle and confirm the return to IDLE.
  task automatic consume(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({name, "_drop_valid"}, 32'(out_valid), 32'd0);
    check_eq({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string name);
    issue(ta, tb_v, top, name);
    expect_result(ed, eb, eo, name);
    consume(name);
    check_eq({name, "_diff_kept"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_borrow", 32'(borrow), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);

    run_op(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "under");
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "sovf");
    run_op(16'h5A5A, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 1'b0, "zero_b");

    // Backpressure: hold DONE for 5 cycles while a new request is offered.
    issue(16'h1000, 16'h0001, 1'b0, "bp");
    expect_result(16'h0FFF, 1'b0, 1'b0, "bp");
    in_valid = 1'b1;
    a        = 16'h4444;
    b        = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_diff", 32'(diff), 32'h0FFF);
      check_eq("bp_hold_borrow", 32'(borrow), 32'd0);
      check_eq("bp_hold_ovf", 32'(ovf), 32'd0);
      check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    check_eq("bp_after_diff", 32'(diff), 32'h0FFF);
    tick();
    check_eq("bp_no_stray_run", 32'(in_ready), 32'd1);

    // Reset in the 2nd RUN cycle discards the operation.
    issue(16'h1234, 16'h0235, 1'b0, "mid_rst");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_diff", 32'(diff), 32'd0);
    run_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, "post_rst");

    // Back-to-back issue right after the consume edge.
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, "b2b");

`ifdef NIBBLE_SUB_ADD_OP_EN
    run_op(16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, "add_carry");
    run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, "sub_after_add");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
